// File: rtl/tree_serializer_scheduler_if.sv
// Handshake and word bus between the requesters/serializer side and tree_serializer_scheduler.
// Requester-facing valid/ready/data plus the serializer-facing word, load and phase outputs.
`ifndef TREE_FROM
`define TREE_FROM 8
`endif
`ifndef TREE_LOGFROM
`define TREE_LOGFROM 3
`endif

interface tree_serializer_scheduler_if #(
  parameter int FROM    = `TREE_FROM,
  parameter int LOGFROM = `TREE_LOGFROM,
  parameter int NREQ    = 4,
  parameter int LOGNREQ = 2
);
  logic                    enable_i;
  logic [NREQ-1:0]         req_valid_i;
  logic [NREQ*FROM-1:0]    req_data_i;
  logic [NREQ-1:0]         req_ready_o;
  logic [FROM-1:0]         word_o;
  logic                    load_o;
  logic                    word_valid_o;
  logic [LOGNREQ-1:0]      grant_id_o;
  logic [LOGFROM-1:0]      phase_o;

  modport master (
    output enable_i, req_valid_i, req_data_i,
    input  req_ready_o, word_o, load_o, word_valid_o, grant_id_o, phase_o
  );

  modport slave (
    input  enable_i, req_valid_i, req_data_i,
    output req_ready_o, word_o, load_o, word_valid_o, grant_id_o, phase_o
  );
endinterface

// File: rtl/tree_serializer_scheduler.sv
// Round-robin arbiter feeding one FROM-bit word per FROM-cycle period to the tree serializer; TREE_SCHED_IDLE_EN selects idle-word vs repeat-last-word.
// Latency 1 clk from decision cycle (phase FROM-1) to word_o; requesters wait (ready low) until their slot at a decision cycle.
`ifndef TREE_FROM
`define TREE_FROM 8
`endif
`ifndef TREE_LOGFROM
`define TREE_LOGFROM 3
`endif

module tree_serializer_scheduler #(
  parameter int              FROM      = `TREE_FROM,
  parameter int              LOGFROM   = `TREE_LOGFROM,
  parameter int              NREQ      = 4,
  parameter int              LOGNREQ   = 2,
  parameter logic [FROM-1:0] IDLE_WORD = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  tree_serializer_scheduler_if.slave   bus
);

  logic [LOGFROM-1:0] r_phase;
  logic [LOGNREQ-1:0] r_ptr;
  logic               r_load;
  logic [FROM-1:0]    r_word;
  logic               r_word_valid;
  logic [LOGNREQ-1:0] r_grant_id;

  logic               w_dec;
  logic               w_found;
  logic               w_grant;
  logic [LOGNREQ-1:0] w_win;
  logic [LOGNREQ-1:0] w_ptr_nxt;
  int                 w_idx;

  assign w_dec = (r_phase == LOGFROM'(FROM - 1));

  // Rotating priority search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = LOGNREQ'(w_idx);
      end
    end
  end

  assign w_grant   = w_dec && bus.enable_i && w_found;
  assign w_ptr_nxt = (w_win == LOGNREQ'(NREQ - 1)) ? '0 : w_win + LOGNREQ'(1);

  assign bus.req_ready_o = w_grant ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase      <= '0;
      r_ptr        <= '0;
      r_load       <= 1'b0;
      r_word       <= IDLE_WORD;
      r_word_valid <= 1'b0;
      r_grant_id   <= '0;
    end else begin
      r_phase <= r_phase + LOGFROM'(1);
      // Pulses on every wrap to phase 0; the post-reset phase 0 is not a wrap.
      r_load  <= w_dec;
      if (w_grant) begin
        r_word       <= bus.req_data_i[w_win*FROM +: FROM];
        r_word_valid <= 1'b1;
        r_grant_id   <= w_win;
        r_ptr        <= w_ptr_nxt;
      end else if (w_dec) begin
        r_word_valid <= 1'b0;
`ifdef TREE_SCHED_IDLE_EN
        r_word       <= IDLE_WORD;
`else
        r_word       <= r_word;
`endif
      end
    end
  end

  assign bus.word_o       = r_word;
  assign bus.word_valid_o = r_word_valid;
  assign bus.grant_id_o   = r_grant_id;
  assign bus.phase_o      = r_phase;
  assign bus.load_o       = r_load;

endmodule

// File: tb/tb_tree_serializer_scheduler.sv
// Bench for tree_serializer_scheduler: scenario tasks plus randomized traffic against a period-level model.
module tb_tree_serializer_scheduler;
  localparam int FROM    = 8;
  localparam int LOGFROM = 3;
  localparam int NREQ    = 4;
  localparam int LOGNREQ = 2;
  localparam logic [FROM-1:0] IDLE = 8'h00;
  localparam int VW = NREQ + FROM + 1 + LOGNREQ + LOGFROM + 1;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // model state: outputs as they should be during the current cycle
  int              m_cyc;
  int              m_ptr;
  int              m_gid;
  logic [FROM-1:0] m_word;
  logic            m_wv;
  logic            m_load;

  tree_serializer_scheduler_if #(.FROM(FROM), .LOGFROM(LOGFROM), .NREQ(NREQ), .LOGNREQ(LOGNREQ)) bus ();

  tree_serializer_scheduler #(
    .FROM(FROM), .LOGFROM(LOGFROM), .NREQ(NREQ), .LOGNREQ(LOGNREQ), .IDLE_WORD(IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (reset === 1'b1 && (m_cyc % FROM) == FROM - 1 && bus.enable_i === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (r == '0 && bus.req_valid_i[k] === 1'b1) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_ready(), m_word, m_wv, LOGNREQ'(m_gid), LOGFROM'(m_cyc % FROM), m_load};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.req_ready_o, bus.word_o, bus.word_valid_o, bus.grant_id_o, bus.phase_o, bus.load_o};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ptr = 0; m_gid = 0; m_word = IDLE; m_wv = 1'b0; m_load = 1'b0;
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] r;
    logic            dec;
    r   = exp_ready();
    dec = ((m_cyc % FROM) == FROM - 1);
    if (r != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (r[k]) begin
          m_word = bus.req_data_i[k*FROM +: FROM];
          m_gid  = k;
          m_ptr  = (k + 1) % NREQ;
        end
      end
      m_wv = 1'b1;
    end else if (dec) begin
      m_wv = 1'b0;
`ifdef TREE_SCHED_IDLE_EN
      m_word = IDLE;
`endif
    end
    m_load = dec;
    m_cyc++;
  endtask

  // advance one clock; called at posedge+1, returns at posedge+1
  task automatic adv();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic align();
    while ((m_cyc % FROM) != 0) adv();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable_i = 1'b1; bus.req_valid_i = '0; bus.req_data_i = '0;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== exp_vec())
      begin bad++; $display("FAIL reset_vals got=%h exp=%h", obs_vec(), exp_vec()); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 2*FROM + 2; c++) begin
      @(negedge clk);
      total++;
      if (obs_vec() !== exp_vec())
        begin bad++; $display("FAIL reset_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      total++;
      if (bus.load_o !== (c == FROM || c == 2*FROM))
        begin bad++; $display("FAIL load_pulse c=%0d got=%b", c, bus.load_o); end
      adv();
    end
  endtask

  task automatic test_single();
    align();
    bus.req_data_i = {8'h11, 8'h3C, 8'h22, 8'h33};
    bus.req_valid_i = 4'b0100;
    for (int c = 0; c < FROM; c++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready_o !== ((c == FROM-1) ? 4'b0100 : 4'b0000))
        begin bad++; $display("FAIL single_ready c=%0d got=%b", c, bus.req_ready_o); end
      total++;
      if (obs_vec() !== exp_vec())
        begin bad++; $display("FAIL single_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      adv();
    end
    bus.req_valid_i = '0;
    for (int c = 0; c < FROM; c++) begin
      @(negedge clk);
      total++;
      if ({bus.word_o, bus.grant_id_o, bus.word_valid_o} !== {8'h3C, 2'd2, 1'b1})
        begin bad++; $display("FAIL single_hold c=%0d got=%h/%0d/%b", c, bus.word_o, bus.grant_id_o, bus.word_valid_o); end
      adv();
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    bus.req_data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid_i = '1;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < FROM; c++) begin
        @(negedge clk);
        total++;
        if (obs_vec() !== exp_vec())
          begin bad++; $display("FAIL rr_run p=%0d c=%0d got=%h exp=%h", p, c, obs_vec(), exp_vec()); end
        adv();
      end
      @(negedge clk);
      total++;
      if (bus.grant_id_o !== LOGNREQ'(exp_seq[p]) || bus.word_valid_o !== 1'b1 || bus.word_o !== FROM'(8'h10 + exp_seq[p]))
        begin bad++; $display("FAIL rr_grant p=%0d got=%0d exp=%0d", p, bus.grant_id_o, exp_seq[p]); end
      @(posedge clk); #1;
      model_edge();
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_idle();
    logic [FROM-1:0] exp_w;
`ifdef TREE_SCHED_IDLE_EN
    exp_w = IDLE;
`else
    exp_w = 8'hA5;
`endif
    align();
    bus.req_data_i[0 +: FROM] = 8'hA5;
    bus.req_valid_i = 4'b0001;
    repeat (FROM) adv();
    @(negedge clk);
    total++;
    if (bus.word_o !== 8'hA5 || bus.word_valid_o !== 1'b1)
      begin bad++; $display("FAIL idle_serve got=%h/%b exp=a5/1", bus.word_o, bus.word_valid_o); end
    bus.req_valid_i = '0;
    for (int c = 0; c < FROM; c++) begin
      if (c != 0) @(negedge clk);
      total++;
      if (obs_vec() !== exp_vec())
        begin bad++; $display("FAIL idle_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      adv();
    end
    @(negedge clk);
    total++;
    if (bus.word_o !== exp_w || bus.word_valid_o !== 1'b0 || bus.load_o !== 1'b1)
      begin bad++; $display("FAIL idle_word got=%h/%b/%b exp=%h/0/1", bus.word_o, bus.word_valid_o, bus.load_o, exp_w); end
    @(posedge clk); #1;
    model_edge();
  endtask

  task automatic test_enable();
    int g0;
    align();
    g0 = m_gid;
    bus.req_data_i[1*FROM +: FROM] = 8'h5A;
    bus.req_valid_i = 4'b0010;
    bus.enable_i = 1'b0;
    for (int c = 0; c < FROM; c++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready_o !== 4'b0000)
        begin bad++; $display("FAIL en_ready c=%0d got=%b", c, bus.req_ready_o); end
      adv();
    end
    @(negedge clk);
    total++;
    if (bus.word_valid_o !== 1'b0 || bus.grant_id_o !== LOGNREQ'(g0))
      begin bad++; $display("FAIL en_gated got=%b/%0d exp=0/%0d", bus.word_valid_o, bus.grant_id_o, g0); end
    @(posedge clk); #1;
    model_edge();
    bus.enable_i = 1'b1;
    for (int c = 1; c < FROM; c++) adv();
    @(negedge clk);
    total++;
    if (bus.grant_id_o !== 2'd1 || bus.word_valid_o !== 1'b1 || bus.word_o !== 8'h5A)
      begin bad++; $display("FAIL en_regrant got=%0d/%b/%h exp=1/1/5a", bus.grant_id_o, bus.word_valid_o, bus.word_o); end
    @(posedge clk); #1;
    model_edge();
    bus.req_valid_i = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid_i[k]) begin
          if ($urandom_range(7) == 0) bus.req_valid_i[k] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          bus.req_data_i[k*FROM +: FROM] = FROM'($urandom);
          bus.req_valid_i[k] = 1'b1;
        end
      end
      bus.enable_i = ($urandom_range(9) != 0);
      @(negedge clk);
      total++;
      if (obs_vec() !== exp_vec())
        begin bad++; $display("FAIL rand c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      adv();
    end
    bus.enable_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = '1;
    repeat (FROM + 3) adv();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== {NREQ'(0), IDLE, 1'b0, LOGNREQ'(0), LOGFROM'(0), 1'b0})
      begin bad++; $display("FAIL reset_mid got=%h", obs_vec()); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 2*FROM; c++) begin
      @(negedge clk);
      total++;
      if (obs_vec() !== exp_vec())
        begin bad++; $display("FAIL reset_mid_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_idle();
    test_enable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
